// File: rtl/par_frame_pkg.sv
// Shared types and constants for the even-parity framed serial transmitter.
package par_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/par_reduce.sv
// Combinational even-parity generator: XOR of all bits of the word.
module par_reduce #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_data,
    output logic         o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/par_frame_tx.sv
// Framed serial transmitter: start, N data bits LSB first, even parity, stop.
// Optional PAR_ERR_INJECT_EN adds err_inj to invert the parity of one frame.
module par_frame_tx
    import par_frame_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PAR_ERR_INJECT_EN
    input  logic         err_inj,
`endif
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         tx_out,
    output logic         busy,
    output logic         frame_done,
    output logic [2:0]   dbg_state
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = $clog2(N);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_cyc;
    logic [BW-1:0] r_bit;
    logic [N-1:0]  r_shift;
    logic          r_par;
    logic          r_tx;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;

    logic          w_par;
    logic          w_par_lat;
    logic          w_take;
    logic          w_cyc_last;

    par_reduce #(.N(N)) u_reduce (
        .i_data   (s_data),
        .o_parity (w_par)
    );

`ifdef PAR_ERR_INJECT_EN
    assign w_par_lat = w_par ^ err_inj;
`else
    assign w_par_lat = w_par;
`endif

    // Handshake: a word transfers on any rising edge where s_valid && s_ready;
    // s_ready is high only in IDLE, and s_valid while not ready is ignored.
    assign w_take     = s_valid && r_ready;
    assign w_cyc_last = (r_cyc == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= LINE_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_shift <= s_data;
                        r_par   <= w_par_lat;
                        r_state <= START;
                        r_tx    <= LINE_START;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cyc   <= '0;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    if (w_cyc_last) begin
                        r_cyc   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (w_cyc_last) begin
                        r_cyc <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= PARITY;
                            r_tx    <= r_par;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_cyc_last) begin
                        r_cyc   <= '0;
                        r_state <= STOP;
                        r_tx    <= LINE_IDLE;
                        // A one-cycle stop bit is its own final cycle.
                        r_done  <= (CLKS_PER_BIT == 1);
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (w_cyc_last) begin
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cyc  <= r_cyc + 1'b1;
                        r_done <= (CLKS_PER_BIT > 1) && (r_cyc == CYC_PRE);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cyc   <= '0;
                    r_bit   <= '0;
                    r_tx    <= LINE_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_par_frame_tx.sv
// Randomized self-checking bench for par_frame_tx (N=8/C=4 and N=2/C=1 instances).
module tb_par_frame_tx;
    import par_frame_pkg::*;

    localparam int N0 = 8;
    localparam int C0 = 4;
    localparam int N1 = 2;
    localparam int C1 = 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N0-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          tx_out;
    logic          busy;
    logic          frame_done;
    logic [2:0]    dbg_state;

    logic [N1-1:0] s1_data;
    logic          s1_valid;
    logic          s1_ready;
    logic          tx1_out;
    logic          busy1;
    logic          frame_done1;
    logic [2:0]    dbg1_state;

`ifdef PAR_ERR_INJECT_EN
    logic err_inj;
    logic err1_inj;
`endif

    par_frame_tx #(.N(N0), .CLKS_PER_BIT(C0)) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PAR_ERR_INJECT_EN
        .err_inj    (err_inj),
`endif
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    par_frame_tx #(.N(N1), .CLKS_PER_BIT(C1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
`ifdef PAR_ERR_INJECT_EN
        .err_inj    (err1_inj),
`endif
        .s_data     (s1_data),
        .s_valid    (s1_valid),
        .s_ready    (s1_ready),
        .tx_out     (tx1_out),
        .busy       (busy1),
        .frame_done (frame_done1),
        .dbg_state  (dbg1_state)
    );

    // scoreboard
    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // Reference frame: line level for every clock of the frame, built from the framing rules.
    task automatic model_frame(input logic [7:0] d, input int n, input int c, input logic inj);
        int ones;
        logic [7:0] dv;
        logic par;
        ones = 0;
        dv = d;
        for (int i = 0; i < n; i++) ones += int'(dv[i]);
        par = ((ones % 2) == 1) ^ inj;
        for (int k = 0; k < c; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < c; k++) exp_q.push_back(dv[i]);
        for (int k = 0; k < c; k++) exp_q.push_back(par);
        for (int k = 0; k < c; k++) exp_q.push_back(1'b1);
    endtask

    task automatic check_frame0(input logic [7:0] d, input logic inj);
        int len;
        logic [0:0] e;
        len = (N0 + 3) * C0;
        model_frame(d, N0, C0, inj);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("tx0 d=%02h c%0d", d, i), tx_out, e);
            check_eq($sformatf("busy0 c%0d", i), busy, 1'b1);
            check_eq($sformatf("ready0 c%0d", i), s_ready, 1'b0);
            check_eq($sformatf("done0 c%0d", i), frame_done, i == len - 1);
        end
    endtask

    task automatic check_frame1(input logic [7:0] d);
        int len;
        logic [0:0] e;
        len = (N1 + 3) * C1;
        model_frame(d, N1, C1, 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("tx1 d=%0h c%0d", d, i), tx1_out, e);
            check_eq($sformatf("busy1 c%0d", i), busy1, 1'b1);
            check_eq($sformatf("ready1 c%0d", i), s1_ready, 1'b0);
            check_eq($sformatf("done1 c%0d", i), frame_done1, i == len - 1);
        end
    endtask

    // driver tasks
    task automatic send0(input logic [7:0] d, input logic inj);
        int k;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready0_wait", s_ready, 1'b1);
        check_eq("idle0_tx", tx_out, 1'b1);
        check_eq("idle0_busy", busy, 1'b0);
        s_data  = d;
        s_valid = 1'b1;
`ifdef PAR_ERR_INJECT_EN
        err_inj = inj;
`endif
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
`ifdef PAR_ERR_INJECT_EN
        err_inj = 1'b0;
`endif
        check_frame0(d, inj);
    endtask

    task automatic send1(input logic [1:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (!s1_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready1_wait", s1_ready, 1'b1);
        s1_data  = d;
        s1_valid = 1'b1;
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        s1_data  = 2'($urandom);
        check_frame1({6'd0, d});
    endtask

    initial begin
        logic done_seen;
        logic inj;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s1_valid = 1'b0;
        s1_data  = '0;
`ifdef PAR_ERR_INJECT_EN
        err_inj  = 1'b0;
        err1_inj = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_eq("rst_tx", tx_out, 1'b1);
        check_eq("rst_ready", s_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_state", dbg_state == IDLE, 1'b1);
        check_eq("rst1_tx", tx1_out, 1'b1);
        check_eq("rst1_ready", s1_ready, 1'b1);
        check_eq("rst1_state", dbg1_state == IDLE, 1'b1);

        send0(8'hA5, 1'b0);
        send0(8'h07, 1'b0);
        send0(8'h00, 1'b0);
        send0(8'hFF, 1'b0);

        // s_valid held across two frames
        @(negedge clk);
        s_data  = 8'h3C;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_data = 8'h81;
        check_frame0(8'h3C, 1'b0);
        @(negedge clk);
        check_eq("gap_tx", tx_out, 1'b1);
        check_eq("gap_ready", s_ready, 1'b1);
        check_eq("gap_busy", busy, 1'b0);
        @(posedge clk);
        #1 s_valid = 1'b0;
        check_frame0(8'h81, 1'b0);

        // reset during data bit 3
        @(negedge clk);
        s_data  = 8'h5A;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("pre_rst_bit3", tx_out, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_tx", tx_out, 1'b1);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_ready", s_ready, 1'b1);
        done_seen = frame_done;
        repeat (40) begin
            @(negedge clk);
            done_seen = done_seen | frame_done;
        end
        check_eq("abort_no_done", done_seen, 1'b0);
        send0(8'h01, 1'b0);

`ifdef PAR_ERR_INJECT_EN
        send0(8'hA5, 1'b1);
        send0(8'hA5, 1'b0);
`endif

        for (int t = 0; t < 16; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            inj = 1'b0;
`ifdef PAR_ERR_INJECT_EN
            inj = 1'($urandom_range(0, 1));
`endif
            send0(8'($urandom_range(0, 255)), inj);
        end

        send1(2'b10);
        send1(2'b01);
        send1(2'b11);
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send1(2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/par_frame_tx.md
Name: par_frame_tx

Overview:
- Serial transmit controller built around an even-parity datapath.
- Accepts N-bit words over a valid/ready handshake and computes the even-parity bit once per word.
- Sends each word as a framed serial stream: start bit, N data bits LSB first, parity bit, stop bit.
- Sits between a parallel word source and a single-wire serial link.

Parameters:
- N, 8, data word width in bits; legal range N >= 2.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  N  word to transmit.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  block can accept a word.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - Outputs after the edge: tx_out=1, s_ready=1, busy=0, frame_done=0.
  - Bit and cycle counters clear to 0.
  - Reset mid-frame aborts the frame immediately, with no stop bit and no frame_done.
- Handshake:
  - s_ready=1 only in IDLE.
  - A transfer occurs when s_valid && s_ready at a rising edge.
  - On transfer, s_data and its even-parity bit (XOR of all N bits) are latched into a shift register and a parity flop.
  - s_data need not be held after the transfer.
  - s_valid high while s_ready=0 has no effect and is not an error.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: tx_out=1. On transfer, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: tx_out = shift_reg[0], each bit held CLKS_PER_BIT cycles, then shift right. After N bits, go to PARITY.
  - PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle of STOP. Next state IDLE.
- Counters:
  - cycle counter width $clog2(CLKS_PER_BIT) with a minimum of 1; wraps to 0 at CLKS_PER_BIT-1.
  - bit counter width $clog2(N).
- Timing:
  - The first START cycle is the cycle after the accepting edge.
  - A frame occupies exactly (N+3)*CLKS_PER_BIT cycles.
  - With s_valid held high, back-to-back frames are separated by exactly one IDLE cycle (tx_out=1, s_ready=1).
- busy = (state != IDLE).
- All outputs are registered or decoded from registered state only; no combinational path from s_valid or s_data to any output.
- Parity rule: data bits plus parity bit always contain an even number of ones. Examples: 0x00 -> 0, 0xFF -> 0, 0x01 -> 1.
- CLKS_PER_BIT=1: every state still lasts exactly one cycle per bit. No state may be skipped or merged.

Optional Feature:
- Macro: PAR_ERR_INJECT_EN.
- Defined: adds input port err_inj (1 bit).
  - If err_inj=1 on the accepting edge, the latched parity bit is inverted for that frame only.
  - Used to exercise downstream parity checkers.
- Not defined: the port does not exist and parity is always correct.
- Timing and handshake are identical in both builds.

Decomposition:
- Package par_frame_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3 bits;
  - localparams for idle and start line levels (1/0);
  - a function for counter width with a minimum of 1.
- Sub-module par_reduce (parameter N): purely combinational XOR reduction of an N-bit word to its even-parity bit.
  - Instantiated once on s_data.
  - The controller only registers its output.

Test Plan:
- N=8, CLKS_PER_BIT=4, send 0xA5 -> tx_out sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 4 cycles. frame_done pulses at cycle 44 after accept.
- Send 0x07 -> parity bit 1; send 0x00 -> parity bit 0. busy high for exactly 44 cycles each.
- s_valid held high with 0x3C then 0x81 -> exactly one IDLE cycle between frames. Parity bits 0 then 0. The second word is not accepted while busy.
- Assert rst for one cycle during DATA bit 3 -> next cycle tx_out=1, busy=0, s_ready=1, no frame_done. The next frame (0x01) is correct, with parity 1.
- CLKS_PER_BIT=1, N=2, send 2'b10 -> tx_out 0,0,1,1,1 over 5 cycles. frame_done on cycle 5.
- PAR_ERR_INJECT_EN defined, err_inj=1 with 0xA5 -> parity bit 1. The following frame sent with err_inj=0 has correct parity 0.
